// File: rtl/match_pair_buffer.sv
// rtl/match_pair_buffer.sv - FWFT FIFO capturing matcher pairs and frame markers; stats under MATCH_BUF_STATS_EN
module match_pair_buffer #(
    parameter int DEPTH = 64,
    parameter int AW    = 6
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_valid,
    input  logic [9:0]    i_src_x,
    input  logic [9:0]    i_src_y,
    input  logic [9:0]    i_dst_x,
    input  logic [9:0]    i_dst_y,
    input  logic          i_end,
    input  logic          i_ready,
    output logic          o_valid,
    output logic          o_pair,
    output logic          o_end,
    output logic [9:0]    o_src_x,
    output logic [9:0]    o_src_y,
    output logic [9:0]    o_dst_x,
    output logic [9:0]    o_dst_y,
    output logic [AW:0]   o_count,
    output logic          o_overflow,
    output logic [15:0]   o_last_frame_pairs,
    output logic [15:0]   o_drop_cnt
);

    localparam int EW = 42;
    localparam logic [AW:0] FULL_C   = (AW+1)'(DEPTH);
    localparam logic [AW:0] FULLM1_C = (AW+1)'(DEPTH - 1);

    logic [EW-1:0] mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          overflow_q, overflow_d;
    logic          req;
    logic          accept;
    logic          pop;
    logic [EW-1:0] wr_entry;
    logic [EW-1:0] head;

    // Pair-only writes stop one short of full so a frame marker always fits.
    always_comb begin
        req      = i_valid | i_end;
        accept   = req & (i_end ? (count_q < FULL_C) : (count_q < FULLM1_C));
        pop      = (count_q != '0) & i_ready;
        wr_entry = {i_valid, i_end,
                    i_valid ? {i_src_x, i_src_y, i_dst_x, i_dst_y} : 40'd0};

        wr_ptr_d = accept ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop    ? rd_ptr_q + AW'(1) : rd_ptr_q;

        count_d = count_q;
        case ({accept, pop})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase

        overflow_d = overflow_q | (req & ~accept);
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst_n && accept) begin
            mem_q[wr_ptr_q] <= wr_entry;
        end
    end

    // Head data is masked while empty so stale memory never leaks out.
    always_comb begin
        head       = (count_q != '0) ? mem_q[rd_ptr_q] : '0;
        o_valid    = (count_q != '0);
        o_pair     = head[41];
        o_end      = head[40];
        o_src_x    = head[39:30];
        o_src_y    = head[29:20];
        o_dst_x    = head[19:10];
        o_dst_y    = head[9:0];
        o_count    = count_q;
        o_overflow = overflow_q;
    end

`ifdef MATCH_BUF_STATS_EN
    logic [15:0] frame_cnt_q, frame_cnt_d;
    logic [15:0] last_pairs_q, last_pairs_d;
    logic [15:0] drop_cnt_q, drop_cnt_d;

    // A frame end closes the frame even when its marker is dropped.
    always_comb begin
        frame_cnt_d  = frame_cnt_q;
        last_pairs_d = last_pairs_q;
        drop_cnt_d   = drop_cnt_q;
        if (i_end) begin
            last_pairs_d = frame_cnt_q + ((accept & i_valid) ? 16'd1 : 16'd0);
            frame_cnt_d  = '0;
        end else if (accept & i_valid) begin
            frame_cnt_d = frame_cnt_q + 16'd1;
        end
        if (req & ~accept & (drop_cnt_q != 16'hFFFF)) begin
            drop_cnt_d = drop_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            frame_cnt_q  <= '0;
            last_pairs_q <= '0;
            drop_cnt_q   <= '0;
        end else begin
            frame_cnt_q  <= frame_cnt_d;
            last_pairs_q <= last_pairs_d;
            drop_cnt_q   <= drop_cnt_d;
        end
    end

    assign o_last_frame_pairs = last_pairs_q;
    assign o_drop_cnt         = drop_cnt_q;
`else
    assign o_last_frame_pairs = 16'd0;
    assign o_drop_cnt         = 16'd0;
`endif

endmodule

// File: tb/tb_match_pair_buffer.sv
// tb/tb_match_pair_buffer.sv - directed self-checking bench for match_pair_buffer
module tb_match_pair_buffer;

`ifdef MATCH_BUF_STATS_EN
    localparam bit STATS_C = 1'b1;
`else
    localparam bit STATS_C = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_end, in_ready;
    logic [9:0]  src_x, src_y, dst_x, dst_y;
    logic        out_valid, out_pair, out_end;
    logic [9:0]  out_src_x, out_src_y, out_dst_x, out_dst_y;
    logic [6:0]  out_count;
    logic        out_overflow;
    logic [15:0] out_last_pairs, out_drop_cnt;

    int n_asserts = 0;
    int n_fail    = 0;

    logic [39:0] sb [$];
    logic [39:0] exp_head;
    logic [39:0] head_now;

    always #5 clk = ~clk;

    match_pair_buffer #(.DEPTH(64), .AW(6)) dut (
        .i_clk              (clk),
        .i_rst_n            (rst_n),
        .i_valid            (in_valid),
        .i_src_x            (src_x),
        .i_src_y            (src_y),
        .i_dst_x            (dst_x),
        .i_dst_y            (dst_y),
        .i_end              (in_end),
        .i_ready            (in_ready),
        .o_valid            (out_valid),
        .o_pair             (out_pair),
        .o_end              (out_end),
        .o_src_x            (out_src_x),
        .o_src_y            (out_src_y),
        .o_dst_x            (out_dst_x),
        .o_dst_y            (out_dst_y),
        .o_count            (out_count),
        .o_overflow         (out_overflow),
        .o_last_frame_pairs (out_last_pairs),
        .o_drop_cnt         (out_drop_cnt)
    );

    function automatic logic [39:0] mk(input int n);
        return {10'(n), 10'(n + 1), 10'(n + 2), 10'(n + 3)};
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic e, input logic [39:0] d);
        in_valid = v;
        in_end   = e;
        {src_x, src_y, dst_x, dst_y} = d;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        head_now = {out_src_x, out_src_y, out_dst_x, out_dst_y};
    endtask

    initial begin
        int sent;
        int cyc;
        rst_n    = 1'b0;
        in_ready = 1'b0;
        drive(1'b0, 1'b0, 40'd0);
        tick();
        tick();
        rst_n = 1'b1;

        // reset state
        check("rst_valid", out_valid, 0);
        check("rst_pair", out_pair, 0);
        check("rst_end", out_end, 0);
        check("rst_data", head_now, 0);
        check("rst_count", out_count, 0);
        check("rst_ovf", out_overflow, 0);
        check("rst_last", out_last_pairs, 0);
        check("rst_drop", out_drop_cnt, 0);

        // three pairs then end, consumer always ready
        in_ready = 1'b1;
        drive(1'b1, 1'b0, {10'd1, 10'd2, 10'd3, 10'd4});
        tick();
        check("f1_valid", out_valid, 1);
        check("f1_p1", head_now, {10'd1, 10'd2, 10'd3, 10'd4});
        check("f1_cnt1", out_count, 1);
        drive(1'b1, 1'b0, {10'd5, 10'd6, 10'd7, 10'd8});
        tick();
        check("f1_p2", head_now, {10'd5, 10'd6, 10'd7, 10'd8});
        check("f1_cnt2", out_count, 1);
        drive(1'b1, 1'b0, {10'd9, 10'd10, 10'd11, 10'd12});
        tick();
        check("f1_p3", head_now, {10'd9, 10'd10, 10'd11, 10'd12});
        drive(1'b0, 1'b1, 40'd0);
        tick();
        check("f1_mk_pair", out_pair, 0);
        check("f1_mk_end", out_end, 1);
        check("f1_mk_data", head_now, 0);
        check("f1_last", out_last_pairs, STATS_C ? 3 : 0);
        drive(1'b0, 1'b0, 40'd0);
        tick();
        check("f1_empty", out_valid, 0);
        check("f1_cnt0", out_count, 0);

        // pair and end in the same cycle
        in_ready = 1'b0;
        drive(1'b1, 1'b1, {10'd100, 10'd200, 10'd101, 10'd201});
        tick();
        check("both_cnt", out_count, 1);
        check("both_pair", out_pair, 1);
        check("both_end", out_end, 1);
        check("both_data", head_now, {10'd100, 10'd200, 10'd101, 10'd201});
        check("both_last", out_last_pairs, STATS_C ? 1 : 0);
        drive(1'b0, 1'b0, 40'd0);
        in_ready = 1'b1;
        tick();
        check("both_drain", out_count, 0);

        // overflow: 70 pairs with no consumer
        in_ready = 1'b0;
        for (int i = 0; i < 70; i++) begin
            drive(1'b1, 1'b0, mk(i + 1));
            tick();
        end
        check("ovf_cnt", out_count, 63);
        check("ovf_flag", out_overflow, 1);
        check("ovf_drop", out_drop_cnt, STATS_C ? 7 : 0);
        check("ovf_head", head_now, mk(1));
        drive(1'b0, 1'b1, 40'd0);
        tick();
        check("ovf_end_cnt", out_count, 64);
        check("ovf_end_drop", out_drop_cnt, STATS_C ? 7 : 0);
        check("ovf_end_last", out_last_pairs, STATS_C ? 63 : 0);
        tick();
        check("ovf_end2_cnt", out_count, 64);
        check("ovf_end2_drop", out_drop_cnt, STATS_C ? 8 : 0);
        check("ovf_end2_last", out_last_pairs, 0);

        // full, pop and pair-only write together: write rejected
        in_ready = 1'b1;
        drive(1'b1, 1'b0, mk(500));
        tick();
        check("full_rd_cnt", out_count, 63);
        check("full_rd_drop", out_drop_cnt, STATS_C ? 9 : 0);
        check("full_rd_ovf", out_overflow, 1);
        drive(1'b0, 1'b0, 40'd0);
        for (int k = 2; k < 64; k++) begin
            exp_head = mk(k);
            check("drain_head", head_now, exp_head);
            tick();
        end
        check("drain_mk_end", out_end, 1);
        check("drain_mk_pair", out_pair, 0);
        tick();
        check("drain_empty", out_valid, 0);

        // 200 pairs at 1-in-2 rate, consumer toggling, pointers wrap
        sent = 0;
        cyc  = 0;
        while ((sent < 200 || sb.size() != 0) && cyc < 2000) begin
            in_ready = (cyc % 2 == 0);
            if (out_valid && in_ready) begin
                if (sb.size() != 0) begin
                    exp_head = sb.pop_front();
                    check("strm_data", head_now, exp_head);
                    check("strm_pair", out_pair, 1);
                end else begin
                    check("strm_extra", out_valid, 0);
                end
            end
            if ((cyc % 2 == 1) && sent < 200) begin
                drive(1'b1, 1'b0, mk(1000 + sent * 7));
                sb.push_back(mk(1000 + sent * 7));
                sent++;
            end else begin
                drive(1'b0, 1'b0, 40'd0);
            end
            tick();
            cyc++;
        end
        check("strm_timeout", cyc < 2000, 1);
        check("strm_left", sb.size(), 0);
        check("strm_cnt", out_count, 0);
        check("strm_drop", out_drop_cnt, STATS_C ? 9 : 0);

        // reset mid-burst
        in_ready = 1'b0;
        for (int i = 0; i < 20; i++) begin
            drive(1'b1, 1'b0, mk(300 + i));
            tick();
        end
        check("mid_cnt", out_count, 20);
        check("mid_ovf", out_overflow, 1);
        rst_n = 1'b0;
        drive(1'b1, 1'b0, mk(77));
        tick();
        rst_n = 1'b1;
        drive(1'b0, 1'b0, 40'd0);
        check("mrst_valid", out_valid, 0);
        check("mrst_cnt", out_count, 0);
        check("mrst_ovf", out_overflow, 0);
        check("mrst_last", out_last_pairs, 0);
        check("mrst_drop", out_drop_cnt, 0);
        check("mrst_data", head_now, 0);
        tick();
        check("mrst_nostore", out_count, 0);
        drive(1'b1, 1'b0, mk(5));
        tick();
        check("mrst_new_cnt", out_count, 1);
        check("mrst_new_head", head_now, mk(5));

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule

// File: doc/match_pair_buffer.md
# match_pair_buffer

- Downstream of the CHIP matcher output. Captures matched coordinate pairs (`o_valid` / `o_src_coor_*` / `o_dst_coor_*`) and frame boundaries (`o_end`).
- Stores them in a synchronous FIFO with frame markers embedded.
- Presents them to a slower consumer (pose estimator or host readout) over a valid/ready handshake.
- The matcher has no back-pressure, so this block absorbs bursts and flags loss.

## Interface

Parameters:

- `DEPTH`, 64: FIFO entries; must be a power of two, ≥ 4.
- `AW`, 6: pointer width, log2(`DEPTH`).

Ports:

- `i_clk` input 1: clock.
- `i_rst_n` input 1: reset, synchronous, active-low.
- `i_valid` input 1: matched pair present this cycle.
- `i_src_x` input 10: source keypoint X.
- `i_src_y` input 10: source keypoint Y.
- `i_dst_x` input 10: destination keypoint X.
- `i_dst_y` input 10: destination keypoint Y.
- `i_end` input 1: frame boundary pulse (matcher `o_end`).
- `i_ready` input 1: consumer accepts the head entry.
- `o_valid` output 1: head entry available.
- `o_pair` output 1: head entry carries a valid pair.
- `o_end` output 1: head entry carries a frame-end marker.
- `o_src_x` output 10: head entry source X.
- `o_src_y` output 10: head entry source Y.
- `o_dst_x` output 10: head entry destination X.
- `o_dst_y` output 10: head entry destination Y.
- `o_count` output AW+1: current occupancy, 0..`DEPTH`.
- `o_overflow` output 1: sticky, an entry was dropped.
- `o_last_frame_pairs` output 16: pairs accepted in the last completed frame (statistics).
- `o_drop_cnt` output 16: dropped write requests, saturating (statistics).

## Operation

- Entry is 42 bits: {pair, end, src_x, src_y, dst_x, dst_y}.
- A write request occurs when `i_valid | i_end`. The entry stores pair=`i_valid` and end=`i_end`. Coordinates are zeroed when `i_valid`=0.
- `i_valid` and `i_end` in the same cycle produce ONE entry with both flags set; no pending state exists.
- Admission is decided on occupancy at the start of the cycle (`count`), ignoring a same-cycle read:
  - pair-only request (end=0): accepted iff `count` < `DEPTH`-1. The last slot is reserved for markers.
  - end-bearing request: accepted iff `count` < `DEPTH`.
  - rejected request: entry discarded, `o_overflow` set to 1 and held, drop counter incremented.
- Read: when `o_valid & i_ready`, the head is popped. `i_ready` with `o_valid`=0 has no effect.
- Simultaneous accepted write and pop: `count` unchanged, both pointers advance.
- Pointers are AW bits and wrap modulo `DEPTH`. `count` is a separate AW+1 register.
- Output is first-word-fall-through. `o_*` data reflect `mem[rd_ptr]` whenever `o_valid`=1 and are don't-care otherwise.
- Reset (synchronous, `i_rst_n`=0 at a rising edge, any time including mid-frame or mid-burst):
  - pointers, `count`, `o_overflow` and both statistics registers cleared;
  - stored data discarded;
  - requests in the reset cycle ignored.

## Timing

- Reset values: `o_valid`=0, `o_pair`=0, `o_end`=0, all coordinate outputs 0, `o_count`=0, `o_overflow`=0, `o_last_frame_pairs`=0, `o_drop_cnt`=0. Memory contents are not reset; data outputs are masked to 0 while empty.
- Latency: a request accepted at edge N gives `o_valid`=1 after edge N when the FIFO was empty (one cycle). There is no combinational path from `i_valid` to `o_valid`.
- Throughput: one write and one read per cycle, sustained.
- `o_count` updates on the same edge as the write/pop that changes it.
- `o_valid` = (`count` != 0), registered state only. No dependency on `i_ready`.

## Configuration

- Macro: `MATCH_BUF_STATS_EN`.
- Defined:
  - a 16-bit per-frame pair counter increments on each accepted entry with pair=1;
  - on an accepted end-bearing entry, the counter value (including a same-entry pair) is copied to `o_last_frame_pairs` and the counter is cleared;
  - a rejected end-bearing request still copies and clears the counter;
  - `o_drop_cnt` increments per rejected request and saturates at 16'hFFFF.
- Undefined: no counters are synthesised; `o_last_frame_pairs` and `o_drop_cnt` are tied to 0. `o_overflow` behaves identically in both builds.

## Test plan

- Reset, then 3 pairs (1,2)->(3,4), (5,6)->(7,8), (9,10)->(11,12), then `i_end` -> with `i_ready`=1, output order is the three pairs then an entry with `o_pair`=0, `o_end`=1; `o_last_frame_pairs`=3 (STATS_EN).
- `i_valid`=1 and `i_end`=1 same cycle with pair (100,200)->(101,201) -> a single entry with `o_pair`=1, `o_end`=1; `o_count` goes 0->1.
- `i_ready`=0, DEPTH=64, 70 consecutive pairs -> `o_count`=63, `o_overflow`=1, `o_drop_cnt`=7; then `i_end` -> accepted, `o_count`=64. A further `i_end` -> dropped, `o_drop_cnt`=8.
- Full at 64 with `i_ready`=1 and a pair-only write in the same cycle -> write rejected (count-before-read rule), `o_count`=63.
- `i_ready` toggling 1/0 every cycle while 200 pairs stream with 1-in-2 `i_valid` -> no drops, output sequence equals input sequence, pointers wrap correctly past 63->0.
- `i_rst_n`=0 for one edge mid-burst with `o_count`=20 and `o_overflow`=1 -> next cycle `o_valid`=0, `o_count`=0, `o_overflow`=0, statistics 0; the pair presented in the reset cycle is not stored.
